// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: write, read and status bundle for the multi-port register file
//   master: writeback/decode side (drives writes, read addresses, clear request)
//   slave : register file (drives read data, wr_ready_o, busy_o, done_o)
interface reg_file_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int NUM_RD = 2
);
    logic                     wa_en_i;
    logic [ADDR_W-1:0]        wa_addr_i;
    logic [DATA_W-1:0]        wa_data_i;
    logic                     wb_en_i;
    logic [ADDR_W-1:0]        wb_addr_i;
    logic [DATA_W-1:0]        wb_data_i;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic                     clr_i;
    logic                     wr_ready_o;
    logic                     busy_o;
    logic                     done_o;
    modport master (
        output wa_en_i, wa_addr_i, wa_data_i, wb_en_i, wb_addr_i, wb_data_i, rd_addr_i, clr_i,
        input  rd_data_o, wr_ready_o, busy_o, done_o
    );
    modport slave (
        input  wa_en_i, wa_addr_i, wa_data_i, wb_en_i, wb_addr_i, wb_data_i, rd_addr_i, clr_i,
        output rd_data_o, wr_ready_o, busy_o, done_o
    );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: 2-write / NUM_RD-read register file with clear sweep after reset and on request
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset (restarts the clear sweep)
//   bus    : write ports A/B (B wins), packed read ports, clr_i, wr_ready_o, busy_o, done_o
module reg_file_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic           clk_i,
    input logic           rst_ni,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                busy;
    logic                wa_acc;
    logic                wb_acc;
    assign busy           = state == CLEAR;
    assign bus.busy_o     = busy;
    assign bus.wr_ready_o = !busy;
    // accepted writes: not sweeping, enabled, and not aimed at a hardwired zero entry
    assign wa_acc = !busy && bus.wa_en_i && !(ZERO_REG != 0 && bus.wa_addr_i == '0);
    assign wb_acc = !busy && bus.wb_en_i && !(ZERO_REG != 0 && bus.wb_addr_i == '0);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= CLEAR;
            clr_cnt     <= '0;
            bus.done_o  <= 1'b0;
        end else begin
            bus.done_o <= 1'b0;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
                // all-ones is DEPTH-1: last entry written, counter wraps to 0 on exit
                if (clr_cnt == '1) begin
                    state      <= IDLE;
                    bus.done_o <= 1'b1;
                end
            end else if (bus.clr_i) begin
                state   <= CLEAR;
                clr_cnt <= '0;
            end
        end
    end
    // storage has no reset; B is written after A so it wins on an address collision
    always_ff @(posedge clk_i) begin
        if (busy) mem[clr_cnt] <= '0;
        if (wa_acc) mem[bus.wa_addr_i] <= bus.wa_data_i;
        if (wb_acc) mem[bus.wb_addr_i] <= bus.wb_data_i;
    end
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
        assign bus.rd_data_o[k*DATA_W +: DATA_W] =
            (ZERO_REG != 0 && a == '0)                  ? '0 :
            (BYPASS != 0 && wb_acc && a == bus.wb_addr_i) ? bus.wb_data_i :
            (BYPASS != 0 && wa_acc && a == bus.wa_addr_i) ? bus.wa_data_i :
                                                            mem[a];
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: vector table + scoreboard bench for a default build and a no-bypass/no-zero 3-port build
module tb_reg_file_mp;
    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] sb [$];

    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2)) b1 ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) b2 ();

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
        dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(b1.slave));
    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0))
        dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(b2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          d2;
        logic        wa_en;
        logic [2:0]  wa_addr;
        logic [15:0] wa_data;
        logic        wb_en;
        logic [2:0]  wb_addr;
        logic [15:0] wb_data;
        logic [8:0]  ra;
        logic [47:0] ex;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(bit d2, logic wa_en, logic [2:0] waa, logic [15:0] wad,
                                logic wb_en, logic [2:0] wba, logic [15:0] wbd,
                                logic [8:0] ra, logic [47:0] ex);
        vec_t v;
        v.d2 = d2; v.wa_en = wa_en; v.wa_addr = waa; v.wa_data = wad;
        v.wb_en = wb_en; v.wb_addr = wba; v.wb_data = wbd; v.ra = ra; v.ex = ex;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic idle_bus();
        b1.wa_en_i = 0; b1.wb_en_i = 0; b1.clr_i = 0;
        b2.wa_en_i = 0; b2.wb_en_i = 0; b2.clr_i = 0;
    endtask

    // one vector: drive after an edge, score at the falling edge, commit at the next edge
    task automatic apply(input vec_t v, input string nm);
        int n;
        logic [15:0] e;
        @(posedge clk); #1;
        idle_bus();
        if (v.d2) begin
            b2.wa_en_i = v.wa_en; b2.wa_addr_i = v.wa_addr; b2.wa_data_i = v.wa_data;
            b2.wb_en_i = v.wb_en; b2.wb_addr_i = v.wb_addr; b2.wb_data_i = v.wb_data;
            b2.rd_addr_i = v.ra;
        end else begin
            b1.wa_en_i = v.wa_en; b1.wa_addr_i = v.wa_addr; b1.wa_data_i = v.wa_data;
            b1.wb_en_i = v.wb_en; b1.wb_addr_i = v.wb_addr; b1.wb_data_i = v.wb_data;
            b1.rd_addr_i = v.ra[5:0];
        end
        n = v.d2 ? 3 : 2;
        for (int k = 0; k < n; k++) sb.push_back(v.ex[k*16 +: 16]);
        @(negedge clk);
        chk({nm, " ready"}, v.d2 ? b2.wr_ready_o : b1.wr_ready_o, 1);
        for (int k = 0; k < n; k++) begin
            e = sb.pop_front();
            chk($sformatf("%s rd%0d", nm, k), v.d2 ? b2.rd_data_o[k*16 +: 16] : b1.rd_data_o[k*16 +: 16], e);
        end
        @(posedge clk); #1;
        idle_bus();
    endtask

    // called at a falling edge with dut1 already sweeping; releases wa_en/clr_i at done
    task automatic check_sweep(input string nm);
        int nb = 0;
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (b1.busy_o) begin
                nb++;
                chk({nm, " ready low"}, b1.wr_ready_o, 0);
                chk({nm, " done low"}, b1.done_o, 0);
            end
            if (b1.done_o) begin
                seen = 1;
                b1.wa_en_i = 0; b1.clr_i = 0;
                chk({nm, " ready at done"}, b1.wr_ready_o, 1);
                chk({nm, " busy at done"}, b1.busy_o, 0);
            end
            if (!seen) @(negedge clk);
        end
        chk({nm, " busy cycles"}, nb, 8);
        chk({nm, " done seen"}, seen, 1);
        @(negedge clk);
        chk({nm, " done one cycle"}, b1.done_o, 0);
    endtask

    initial begin
        rst_n = 0;
        idle_bus();
        b1.wa_addr_i = 0; b1.wa_data_i = 0; b1.wb_addr_i = 0; b1.wb_data_i = 0; b1.rd_addr_i = 0;
        b2.wa_addr_i = 0; b2.wa_data_i = 0; b2.wb_addr_i = 0; b2.wb_data_i = 0; b2.rd_addr_i = 0;

        tbl[0] = mk(0, 1, 5, 16'h1234, 0, 0, 0, {3'd0, 3'd3, 3'd5}, {16'h0, 16'h0, 16'h1234});
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd0, 3'd5}, {16'h0, 16'h0, 16'h1234});
        tbl[2] = mk(0, 1, 3, 16'hAAAA, 1, 3, 16'h5555, {3'd0, 3'd5, 3'd3}, {16'h0, 16'h1234, 16'h5555});
        tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd3, 3'd3}, {16'h0, 16'h5555, 16'h5555});
        tbl[4] = mk(0, 1, 0, 16'hFFFF, 0, 0, 0, {3'd0, 3'd0, 3'd0}, {16'h0, 16'h0, 16'h0});
        tbl[5] = mk(0, 1, 6, 16'h0BEE, 1, 0, 16'hFFFF, {3'd0, 3'd6, 3'd0}, {16'h0, 16'h0BEE, 16'h0});
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd6, 3'd0}, {16'h0, 16'h0BEE, 16'h0});
        tbl[7] = mk(0, 1, 7, 16'h1111, 1, 1, 16'h2222, {3'd0, 3'd1, 3'd7}, {16'h0, 16'h2222, 16'h1111});
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd1, 3'd7}, {16'h0, 16'h2222, 16'h1111});
        tbl[9] = mk(0, 0, 4, 16'h9999, 0, 4, 16'h8888, {3'd0, 3'd5, 3'd4}, {16'h0, 16'h1234, 16'h0});
        tbl[10] = mk(1, 1, 0, 16'hAAAA, 0, 0, 0, {3'd0, 3'd0, 3'd0}, {16'h0, 16'h0, 16'h0});
        tbl[11] = mk(1, 0, 0, 0, 0, 0, 0, {3'd2, 3'd1, 3'd0}, {16'h0, 16'h0, 16'hAAAA});
        tbl[12] = mk(1, 1, 1, 16'h1111, 1, 2, 16'h2222, {3'd0, 3'd2, 3'd1}, {16'hAAAA, 16'h0, 16'h0});
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, {3'd1, 3'd0, 3'd2}, {16'h1111, 16'hAAAA, 16'h2222});
        tbl[14] = mk(1, 1, 4, 16'hAAAA, 1, 4, 16'h5555, {3'd4, 3'd4, 3'd4}, {16'h0, 16'h0, 16'h0});
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, {3'd0, 3'd3, 3'd4}, {16'hAAAA, 16'h0, 16'h5555});

        // reset held: sweeping state, writes blocked, no done
        repeat (3) begin
            @(negedge clk);
            chk("rst busy", b1.busy_o, 1);
            chk("rst ready", b1.wr_ready_o, 0);
            chk("rst done", b1.done_o, 0);
        end
        rst_n = 1;
        check_sweep("init");

        for (int i = 0; i < 8; i++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, {3'd0, 3'(7 - i), 3'(i)}, 48'h0), $sformatf("init zero %0d", i));
        for (int i = 0; i < 8; i++)
            apply(mk(1, 0, 0, 0, 0, 0, 0, {3'(i), 3'(i), 3'(i)}, 48'h0), $sformatf("d2 init zero %0d", i));

        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // fill dut1, then clear with a write to addr 2 and clr_i held through the sweep
        for (int i = 1; i < 8; i++)
            apply(mk(0, 1, 3'(i), 16'h1000 + 16'(i), 0, 0, 0, {3'd0, 3'd0, 3'(i)}, {32'h0, 16'h1000 + 16'(i)}),
                  $sformatf("fill %0d", i));
        @(posedge clk); #1;
        b1.clr_i = 1;
        @(posedge clk); #1;
        b1.wa_en_i = 1; b1.wa_addr_i = 2; b1.wa_data_i = 16'hBEEF;
        @(negedge clk);
        check_sweep("clear");
        for (int i = 0; i < 8; i++)
            apply(mk(0, 0, 0, 0, 0, 0, 0, {3'd0, 3'(7 - i), 3'(i)}, 48'h0), $sformatf("cleared %0d", i));

        // reset during a sweep at clr_cnt = 4
        apply(mk(0, 1, 6, 16'h6666, 0, 0, 0, {3'd0, 3'd0, 3'd6}, {32'h0, 16'h6666}), "pre abort");
        @(posedge clk); #1;
        b1.clr_i = 1;
        @(posedge clk); #1;
        b1.clr_i = 0;
        repeat (4) begin
            @(negedge clk);
            chk("abort sweeping", b1.busy_o, 1);
            chk("abort no done", b1.done_o, 0);
            @(posedge clk);
        end
        @(negedge clk);
        rst_n = 0;
        repeat (2) begin
            @(negedge clk);
            chk("abort rst busy", b1.busy_o, 1);
            chk("abort rst done", b1.done_o, 0);
        end
        rst_n = 1;
        check_sweep("restart");
        apply(mk(0, 0, 0, 0, 0, 0, 0, {3'd0, 3'd7, 3'd6}, 48'h0), "restart cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
